// File: rtl/jt9346_pkg.sv
// Shared op codes, frame constants and state encoding for the 93C46 host master.
package jt9346_pkg;

   localparam logic [2:0] OP_READ  = 3'd0;
   localparam logic [2:0] OP_WRITE = 3'd1;
   localparam logic [2:0] OP_ERASE = 3'd2;
   localparam logic [2:0] OP_EWEN  = 3'd3;
   localparam logic [2:0] OP_EWDS  = 3'd4;
   localparam logic [2:0] OP_ERAL  = 3'd5;
   localparam logic [2:0] OP_WRAL  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   localparam logic [1:0] EE_READ  = 2'b10;
   localparam logic [1:0] EE_WRITE = 2'b01;
   localparam logic [1:0] EE_ERASE = 2'b11;
   localparam logic [1:0] EE_EXT   = 2'b00;

   localparam logic [5:0] F_EWEN = 6'b110000;
   localparam logic [5:0] F_EWDS = 6'b000000;
   localparam logic [5:0] F_ERAL = 6'b100000;
   localparam logic [5:0] F_WRAL = 6'b010000;

   localparam logic [4:0] LEN_SHORT = 5'd9;
   localparam logic [4:0] LEN_LONG  = 5'd25;
   localparam logic [4:0] LEN_DATA  = 5'd16;

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_SHIFT, S_RDATA, S_DESEL, S_POLL, S_DESEL2, S_DONE
   } state_e;

   // Frame is MSB-aligned; short frames leave the data field zero so the
   // line idles low once all meaningful bits have been shifted out.
   function automatic logic [24:0] build_frame(logic [2:0] op, logic [5:0] addr,
                                               logic [15:0] din);
      logic [1:0]  opc;
      logic [5:0]  fld;
      logic [15:0] dat;
      opc = EE_EXT;
      fld = addr;
      dat = '0;
      case (op)
         OP_READ:  opc = EE_READ;
         OP_WRITE: begin opc = EE_WRITE; dat = din; end
         OP_ERASE: opc = EE_ERASE;
         OP_EWEN:  fld = F_EWEN;
         OP_EWDS:  fld = F_EWDS;
         OP_ERAL:  fld = F_ERAL;
         OP_WRAL:  begin fld = F_WRAL; dat = din; end
         default:  fld = '0;
      endcase
      return {1'b1, opc, fld, dat};
   endfunction

   function automatic logic [4:0] frame_len(logic [2:0] op);
      return (op == OP_WRITE || op == OP_WRAL) ? LEN_LONG : LEN_SHORT;
   endfunction

   function automatic logic needs_poll(logic [2:0] op);
      return (op == OP_WRITE || op == OP_ERASE || op == OP_ERAL || op == OP_WRAL);
   endfunction

endpackage

// File: rtl/jt9346_ctrl_tick.sv
// Half-period divider for ee_sclk: strobes mark the end of each half period.
module jt9346_ctrl_tick
   import jt9346_pkg::*;
#(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   input  logic tog,
   output logic rise,
   output logic fall,
   output logic sclk
);

   localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       lvl_q, lvl_d;
   logic       tc;

   assign tc   = (cnt_q == 8'd0);
   assign rise = en && tc && !lvl_q;
   assign fall = en && tc && lvl_q;
   assign sclk = lvl_q;

   // Down-count each half period; toggle the level only when the FSM allows it.
   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (clr) begin
         cnt_d = RELOAD;
         lvl_d = 1'b0;
      end else if (en) begin
         if (tc) begin
            cnt_d = RELOAD;
            if (tog) lvl_d = !lvl_q;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   // Divider registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= RELOAD;
         lvl_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         lvl_q <= lvl_d;
      end
   end

endmodule

// File: rtl/jt9346_ctrl.sv
// Host-side command master for a 93C46-style serial EEPROM.
//   state  | meaning
//   IDLE   | waiting for a command, cmd_ready high
//   SEL    | chip select up, first bit on sdi, one low half period
//   SHIFT  | clock out start bit, opcode, field and optional data
//   RDATA  | READ only: clock in 16 data bits
//   DESEL  | chip select low for one half period
//   POLL   | programming ops: select and sample ready/busy
//   DESEL2 | chip select low after polling
//   DONE   | one-cycle response
module jt9346_ctrl
   import jt9346_pkg::*;
#(
   parameter int          CLKDIV  = 4,
   parameter logic [15:0] BUSY_TO = 16'd4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [5:0]  cmd_addr,
   input  logic [15:0] cmd_din,
   output logic        rsp_valid,
   output logic [15:0] rsp_dout,
   output logic        rsp_err,
   output logic        ee_sclk,
   output logic        ee_sdi,
   input  logic        ee_sdo,
   output logic        ee_scs
);

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [24:0] frame_q, frame_d;
   logic [4:0]  bits_q, bits_d;
   logic [15:0] rd_q, rd_d;
   logic [15:0] poll_q, poll_d;
   logic        err_q, err_d;
   logic [15:0] dout_q, dout_d;
   logic        ready_q, ready_d;
   logic        valid_q, valid_d;
   logic        scs_q, scs_d;
   logic        tick_en, tick_clr, tick_tog, tick_rise, tick_fall;

   assign tick_en  = (state_q != S_IDLE) && (state_q != S_DONE);
   assign tick_tog = (state_q == S_SEL) || (state_q == S_SHIFT) || (state_q == S_RDATA);

   jt9346_ctrl_tick #(.CLKDIV(CLKDIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .clr  (tick_clr),
      .tog  (tick_tog),
      .rise (tick_rise),
      .fall (tick_fall),
      .sclk (ee_sclk)
   );

   assign cmd_ready = ready_q;
   assign rsp_valid = valid_q;
   assign rsp_dout  = dout_q;
   assign rsp_err   = err_q;
   assign ee_sdi    = frame_q[24];
   assign ee_scs    = scs_q;

   // Next-state logic; the divider is cleared whenever a phase must end with sclk low.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      frame_d  = frame_q;
      bits_d   = bits_q;
      rd_d     = rd_q;
      poll_d   = poll_q;
      err_d    = err_q;
      dout_d   = dout_q;
      tick_clr = (state_q == S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && ready_q) begin
               op_d  = cmd_op;
               err_d = 1'b0;
               if (cmd_op == OP_RSVD) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  frame_d = build_frame(cmd_op, cmd_addr, cmd_din);
                  bits_d  = frame_len(cmd_op);
                  state_d = S_SEL;
               end
            end
         end
         S_SEL: begin
            if (tick_rise) state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (tick_fall) begin
               frame_d = {frame_q[23:0], 1'b0};
               bits_d  = bits_q - 5'd1;
            end
            if (tick_rise && bits_q == 5'd0) begin
               if (op_q == OP_READ) begin
                  bits_d  = LEN_DATA;
                  state_d = S_RDATA;
               end else begin
                  tick_clr = 1'b1;
                  state_d  = S_DESEL;
               end
            end
         end
         S_RDATA: begin
            if (tick_fall) begin
               rd_d   = {rd_q[14:0], ee_sdo};
               bits_d = bits_q - 5'd1;
            end
            if (tick_rise && bits_q == 5'd0) begin
               tick_clr = 1'b1;
               state_d  = S_DESEL;
            end
         end
         S_DESEL: begin
            if (tick_rise) begin
               if (needs_poll(op_q)) begin
                  poll_d  = BUSY_TO;
                  state_d = S_POLL;
               end else begin
                  if (op_q == OP_READ) dout_d = rd_q;
                  state_d = S_DONE;
               end
            end
         end
         S_POLL: begin
            if (tick_rise) begin
               if (ee_sdo) begin
                  state_d = S_DESEL2;
               end else if (poll_q <= 16'd1) begin
                  err_d   = 1'b1;
                  state_d = S_DESEL2;
               end else begin
                  poll_d = poll_q - 16'd1;
               end
            end
         end
         S_DESEL2: begin
            if (tick_rise) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_DONE);
      scs_d   = (state_d == S_SEL) || (state_d == S_SHIFT) ||
                (state_d == S_RDATA) || (state_d == S_POLL);
   end

   // State and datapath registers; outputs are registered so the pins never glitch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_READ;
         frame_q <= '0;
         bits_q  <= '0;
         rd_q    <= '0;
         poll_q  <= '0;
         err_q   <= 1'b0;
         dout_q  <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         scs_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         frame_q <= frame_d;
         bits_q  <= bits_d;
         rd_q    <= rd_d;
         poll_q  <= poll_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         scs_q   <= scs_d;
      end
   end

endmodule
